// File: rtl/pipe_hazard_id_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_id_if
// Purpose : ID-stage decode fields in, forwarding selects and stall/bubble out.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_hazard_id_if #(
    parameter int RW = 5
);
    logic [RW-1:0] IDrs;
    logic [RW-1:0] IDrt;
    logic          IDusesRs;
    logic          IDusesRt;
    logic          IDshift;
    logic          IDaluimm;
    logic          IDstore;
    logic          IDwreg;
    logic          IDm2reg;
    logic [RW-1:0] IDwn;
    logic          flush;
    logic [1:0]    selectAlua;
    logic [1:0]    selectAlub;
    logic [1:0]    isStoreHazards;
    logic          stall;
    logic          bubble;

    modport master (
        output IDrs, IDrt, IDusesRs, IDusesRt, IDshift, IDaluimm, IDstore,
               IDwreg, IDm2reg, IDwn, flush,
        input  selectAlua, selectAlub, isStoreHazards, stall, bubble
    );

    modport slave (
        input  IDrs, IDrt, IDusesRs, IDusesRt, IDshift, IDaluimm, IDstore,
               IDwreg, IDm2reg, IDwn, flush,
        output selectAlua, selectAlub, isStoreHazards, stall, bubble
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_id.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_id
// Purpose : ID-stage forwarding-select and load-use stall controller with a
//           private shadow of the EX and MEM destination registers.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_id #(
    parameter int RW = 5
) (
    input  wire logic          clk,
    input  wire logic          clr,
    pipe_hazard_id_if.slave    bus
);
    localparam logic [1:0]    c_SEL_REG = 2'd0;
    localparam logic [1:0]    c_SEL_IMM = 2'd1;
    localparam logic [1:0]    c_SEL_MEM = 2'd2;
    localparam logic [1:0]    c_SEL_WB  = 2'd3;
    localparam logic [1:0]    c_ST_QB   = 2'd0;
    localparam logic [1:0]    c_ST_MEM  = 2'd1;
    localparam logic [1:0]    c_ST_WB   = 2'd2;
    localparam logic [RW-1:0] c_ZERO    = '0;

    // MEM-slot m2reg is never consulted: a load in MEM is already forwardable.
    logic          r_exWreg;
    logic          r_exM2reg;
    logic [RW-1:0] r_exWn;
    logic          r_memWreg;
    logic [RW-1:0] r_memWn;

    logic       w_exRs, w_exRt, w_memRs, w_memRt;
    logic [1:0] w_fwdRs, w_fwdRt;
    logic [1:0] w_selA, w_selB, w_store;
    logic       w_stall, w_bubble;

    always_comb begin
        w_exRs  = r_exWreg  && (r_exWn  != c_ZERO) && (r_exWn  == bus.IDrs);
        w_exRt  = r_exWreg  && (r_exWn  != c_ZERO) && (r_exWn  == bus.IDrt);
        w_memRs = r_memWreg && (r_memWn != c_ZERO) && (r_memWn == bus.IDrs);
        w_memRt = r_memWreg && (r_memWn != c_ZERO) && (r_memWn == bus.IDrt);

        // A producer in EX will sit in MEM when this instruction reaches EX.
        w_fwdRs = w_exRs ? c_SEL_MEM : (w_memRs ? c_SEL_WB : c_SEL_REG);
        w_fwdRt = w_exRt ? c_SEL_MEM : (w_memRt ? c_SEL_WB : c_SEL_REG);

        w_selA = c_SEL_REG;
        if (bus.IDshift)
            w_selA = c_SEL_IMM;
        else if (bus.IDusesRs)
            w_selA = w_fwdRs;

        w_selB = c_SEL_REG;
        if (bus.IDaluimm)
            w_selB = c_SEL_IMM;
        else if (bus.IDusesRt)
            w_selB = w_fwdRt;

        w_store = c_ST_QB;
        if (bus.IDstore)
            w_store = w_exRt ? c_ST_MEM : (w_memRt ? c_ST_WB : c_ST_QB);

        w_stall  = r_exM2reg &&
                   ((bus.IDusesRs && !bus.IDshift && w_exRs) ||
                    (bus.IDusesRt && w_exRt));
        w_bubble = w_stall || bus.flush;
    end

    assign bus.selectAlua     = w_selA;
    assign bus.selectAlub     = w_selB;
    assign bus.isStoreHazards = w_store;
    assign bus.stall          = w_stall;
    assign bus.bubble         = w_bubble;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_exWreg  <= 1'b0;
            r_exM2reg <= 1'b0;
            r_exWn    <= c_ZERO;
            r_memWreg <= 1'b0;
            r_memWn   <= c_ZERO;
        end else begin
            r_memWreg <= r_exWreg;
            r_memWn   <= r_exWn;
            r_exWreg  <= bus.IDwreg  & ~w_bubble;
            r_exM2reg <= bus.IDm2reg & ~w_bubble;
            r_exWn    <= bus.IDwn;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_id.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_id
// Purpose : Directed per-cycle vector table plus async-reset corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_id;
    localparam int c_NV = 28;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    pipe_hazard_id_if #(.RW(5)) bus ();

    pipe_hazard_id #(.RW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, wn;
        logic       uR, uT, sh, imm, st, wr, m2, fl;
        logic [1:0] eA, eB, eS;
        logic       eStall, eBub;
    } vec_t;

    vec_t vt [c_NV];

    function automatic vec_t mk(input int rs, input int rt, input int uR, input int uT,
                                input int sh, input int imm, input int st, input int wr,
                                input int m2, input int wn, input int fl, input int eA,
                                input int eB, input int eS, input int eStall, input int eBub);
        vec_t v;
        v.rs = 5'(rs);  v.rt = 5'(rt);  v.wn = 5'(wn);
        v.uR = 1'(uR);  v.uT = 1'(uT);  v.sh = 1'(sh);  v.imm = 1'(imm);
        v.st = 1'(st);  v.wr = 1'(wr);  v.m2 = 1'(m2);  v.fl = 1'(fl);
        v.eA = 2'(eA);  v.eB = 2'(eB);  v.eS = 2'(eS);
        v.eStall = 1'(eStall);  v.eBub = 1'(eBub);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.IDrs     = v.rs;   bus.IDrt     = v.rt;   bus.IDwn    = v.wn;
        bus.IDusesRs = v.uR;   bus.IDusesRt = v.uT;   bus.IDshift = v.sh;
        bus.IDaluimm = v.imm;  bus.IDstore  = v.st;   bus.IDwreg  = v.wr;
        bus.IDm2reg  = v.m2;   bus.flush    = v.fl;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int eA, input int eB, input int eS,
                            input int eStall, input int eBub);
        check({tag, ".selA"},   int'(bus.selectAlua),     eA);
        check({tag, ".selB"},   int'(bus.selectAlub),     eB);
        check({tag, ".store"},  int'(bus.isStoreHazards), eS);
        check({tag, ".stall"},  int'(bus.stall),          eStall);
        check({tag, ".bubble"}, int'(bus.bubble),         eBub);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            rs rt uR uT sh im st wr m2 wn fl  A B S st bb
        vt[0]  = mk( 1, 2, 1, 1, 0, 0, 0, 1, 0, 3, 0, 0,0,0,0,0); // add $3,$1,$2
        vt[1]  = mk( 1, 2, 1, 1, 0, 0, 0, 1, 0, 5, 0, 0,0,0,0,0); // add $5
        vt[2]  = mk( 5, 5, 1, 1, 0, 0, 0, 1, 0, 6, 0, 2,2,0,0,0); // sub $6,$5,$5
        vt[3]  = mk( 1, 1, 1, 1, 0, 0, 0, 1, 0, 5, 0, 0,0,0,0,0); // add $5
        vt[4]  = mk( 1, 2, 1, 1, 0, 0, 0, 1, 0,10, 0, 0,0,0,0,0); // gap
        vt[5]  = mk( 5, 5, 1, 1, 0, 0, 0, 1, 0, 6, 0, 3,3,0,0,0); // sub $6,$5,$5
        vt[6]  = mk( 1, 4, 1, 0, 0, 1, 0, 1, 1, 4, 0, 0,1,0,0,0); // lw $4
        vt[7]  = mk( 4, 2, 1, 1, 0, 0, 0, 1, 0, 7, 0, 2,0,0,1,1); // add $7,$4 stalls
        vt[8]  = mk( 4, 2, 1, 1, 0, 0, 0, 1, 0, 7, 0, 3,0,0,0,0); // replay
        vt[9]  = mk( 1, 2, 1, 1, 0, 0, 0, 1, 0, 8, 0, 0,0,0,0,0); // add $8
        vt[10] = mk( 9, 8, 1, 1, 0, 1, 1, 0, 0, 8, 0, 0,1,1,0,0); // sw $8
        vt[11] = mk( 1, 2, 1, 1, 0, 0, 0, 1, 0, 8, 0, 0,0,0,0,0); // add $8
        vt[12] = mk( 1, 2, 1, 1, 0, 0, 0, 1, 0,11, 0, 0,0,0,0,0); // gap
        vt[13] = mk( 9, 8, 1, 1, 0, 1, 1, 0, 0, 8, 0, 0,1,2,0,0); // sw $8
        vt[14] = mk( 1, 8, 1, 0, 0, 1, 0, 1, 1, 8, 0, 0,1,0,0,0); // lw $8
        vt[15] = mk( 9, 8, 1, 1, 0, 1, 1, 0, 0, 8, 0, 0,1,1,1,1); // sw $8 stalls
        vt[16] = mk( 9, 8, 1, 1, 0, 1, 1, 0, 0, 8, 0, 0,1,2,0,0); // replay
        vt[17] = mk( 8, 8, 1, 1, 0, 0, 0, 1, 0,12, 0, 0,0,0,0,0); // bubble not forwarded
        vt[18] = mk( 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0,0,0,0,0); // add $0
        vt[19] = mk( 0, 0, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0,0,0,0,0); // or $2,$0,$0
        vt[20] = mk( 1, 1, 1, 1, 0, 0, 0, 1, 0, 5, 0, 0,0,0,0,0); // add $5
        vt[21] = mk( 2, 2, 1, 1, 0, 0, 0, 1, 0, 5, 0, 3,3,0,0,0); // add $5,$2,$2
        vt[22] = mk( 5, 5, 1, 1, 0, 0, 0, 1, 0, 6, 0, 2,2,0,0,0); // EX priority
        vt[23] = mk( 1, 1, 1, 1, 0, 0, 0, 1, 0, 3, 1, 0,0,0,0,1); // add $3 flushed
        vt[24] = mk( 3, 3, 1, 1, 0, 0, 0, 1, 0, 4, 0, 0,0,0,0,0); // sub $4,$3,$3
        vt[25] = mk( 0, 4, 0, 1, 1, 0, 0, 1, 0, 9, 0, 1,2,0,0,0); // sll $9,$4
        vt[26] = mk( 1,13, 1, 0, 0, 1, 0, 1, 1,13, 0, 0,1,0,0,0); // lw $13
        vt[27] = mk(13, 9, 1, 1, 1, 0, 0, 1, 0,14, 0, 1,3,0,0,0); // shift ignores rs

        // Reset state: selects follow only shift/aluimm.
        clr = 1'b1;
        drive(mk(7, 7, 1, 1, 1, 1, 1, 1, 1, 7, 0, 0,0,0,0,0));
        #2;
        checkAll("reset", 1, 1, 0, 0, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,0,0,0,0));
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < c_NV; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            #3;
            checkAll($sformatf("v%0d", i), vt[i].eA, vt[i].eB, vt[i].eS,
                     vt[i].eStall, vt[i].eBub);
        end

        // Reset asserted mid-stall drops the stall without a clock edge.
        @(posedge clk);
        #1;
        drive(mk(1, 4, 1, 0, 0, 1, 0, 1, 1, 4, 0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        drive(mk(4, 2, 1, 1, 0, 0, 0, 1, 0, 7, 0, 0,0,0,0,0));
        #2;
        checkAll("preclr", 2, 0, 0, 1, 1);
        #1;
        clr = 1'b1;
        #1;
        checkAll("midclr", 0, 0, 0, 0, 0);
        bus.flush    = 1'b1;
        bus.IDshift  = 1'b1;
        bus.IDaluimm = 1'b1;
        #1;
        checkAll("clrflush", 1, 1, 0, 0, 1);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,0,0,0,0));
        @(negedge clk);
        clr = 1'b0;

        // Cleared shadow: a reader of $4 gets no forwarding.
        @(posedge clk);
        #1;
        drive(mk(4, 4, 1, 1, 0, 0, 0, 1, 0, 5, 0, 0,0,0,0,0));
        #3;
        checkAll("postclr", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
